hazard_scoreboard: RTL

Parametrised hazard and forwarding controller for the pipelined core, replacing the separate hazard-detection and forwarding units with a single stateful scoreboard. It tracks every in-flight register writer from EX through write-back in a DEPTH-entry shift table. From that table it produces the decode-stage stall and registered per-operand forwarding selects for the EX stage. Pipeline depth, load-use distance and register count are parameters, and a branch flush input is supported.

---
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Combined hazard-detection and forwarding controller. It tracks every
//   in-flight register writer from EX (entry 0) to WB (entry DEPTH-1) in a
//   shift table. From that table it raises the decode-stage stall and
//   registers the per-operand forwarding selects for EX.
//
//   Optional feature macro: HAZ_STATS_EN. When it is defined, stall_cnt and
//   flush_cnt are saturating event counters. When it is undefined, both
//   counters are tied to zero.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_rs1, id_rs2        source register indices
//   id_rs1_used/_rs2_used instruction reads the corresponding source
//   id_rd, id_regwrite    destination index and write enable
//   id_memread            instruction is a load
//   flush                 branch taken in EX; the ID instruction is wrong-path
//   stall                 hold PC and IF/ID (combinational)
//   ex_rs*_fwd_en/_dist   registered forwarding select; dist d picks result bus d
//   stall_cnt, flush_cnt  statistics counters
module hazard_scoreboard #(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned NREG      = 32,
  parameter int unsigned LOAD_DIST = 2,
  localparam int unsigned RW       = $clog2(NREG),
  localparam int unsigned DW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic          stall,
  output logic          ex_rs1_fwd_en,
  output logic [DW-1:0] ex_rs1_dist,
  output logic          ex_rs2_fwd_en,
  output logic [DW-1:0] ex_rs2_dist,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
);

  // Writer table: entry k is the producer that is k stages past EX.
  logic          tv  [DEPTH];
  logic [RW-1:0] trd [DEPTH];
  logic          tld [DEPTH];

  logic          m1, m2;
  logic          l1, l2;
  logic [DW-1:0] d1, d2;
  logic          haz1, haz2;
  logic          go;
  logic          issue;

  // Youngest-match search: the first hit in ascending k wins, and older
  // entries cannot override it.
  always_comb begin
    m1 = 1'b0;
    l1 = 1'b0;
    d1 = '0;
    m2 = 1'b0;
    l2 = 1'b0;
    d2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!m1 && id_rs1_used && (id_rs1 != '0) && tv[k] && (trd[k] == id_rs1)) begin
        m1 = 1'b1;
        l1 = tld[k];
        d1 = DW'(k + 1);
      end
      if (!m2 && id_rs2_used && (id_rs2 != '0) && tv[k] && (trd[k] == id_rs2)) begin
        m2 = 1'b1;
        l2 = tld[k];
        d2 = DW'(k + 1);
      end
    end
  end

  always_comb begin
    haz1  = m1 & l1 & (32'(d1) < LOAD_DIST);
    haz2  = m2 & l2 & (32'(d2) < LOAD_DIST);
    stall = id_valid & ~flush & (haz1 | haz2);
    go    = id_valid & ~stall & ~flush;
    issue = go & id_regwrite & (id_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        tv[k]  <= 1'b0;
        trd[k] <= '0;
        tld[k] <= 1'b0;
      end
    end else begin
      tv[0]  <= issue;
      trd[0] <= id_rd;
      tld[0] <= id_memread & issue;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        tv[k]  <= tv[k-1];
        trd[k] <= trd[k-1];
        tld[k] <= tld[k-1];
      end
    end
  end

  // A stalled, flushed or invalid ID slot sends a bubble into EX, so the
  // selects clear.
  always_ff @(posedge clk) begin
    if (rst || !go) begin
      ex_rs1_fwd_en <= 1'b0;
      ex_rs1_dist   <= '0;
      ex_rs2_fwd_en <= 1'b0;
      ex_rs2_dist   <= '0;
    end else begin
      ex_rs1_fwd_en <= m1;
      ex_rs1_dist   <= d1;
      ex_rs2_fwd_en <= m2;
      ex_rs2_dist   <= d2;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] scnt;
  logic [31:0] fcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      fcnt <= '0;
    end else begin
      if (stall && (scnt != '1)) scnt <= scnt + 32'd1;
      if (flush && (fcnt != '1)) fcnt <= fcnt + 32'd1;
    end
  end

  assign stall_cnt = scnt;
  assign flush_cnt = fcnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
